// File: rtl/light_ctrl_pkg.sv
// Shared lamp encodings and phase codes for the multi-approach signal controller.
// Lamp triplets are {R,Y,G}; phases are legacy-compatible 2-bit constants.
package light_ctrl_pkg;

    localparam logic [2:0] LT_RED    = 3'b100;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_GREEN  = 3'b001;

    localparam logic [1:0] PH_ALLRED = 2'b00;
    localparam logic [1:0] PH_GREEN  = 2'b01;
    localparam logic [1:0] PH_YELLOW = 2'b10;

    // Only the selected approach ever leaves red; an illegal phase code shows red.
    function automatic logic [2:0] lamp_for(input logic [1:0] ph, input logic selected);
        logic [2:0] lamp;
        if (!selected) begin
            lamp = LT_RED;
        end else begin
            case (ph)
                PH_GREEN:  lamp = LT_GREEN;
                PH_YELLOW: lamp = LT_YELLOW;
                default:   lamp = LT_RED;
            endcase
        end
        return lamp;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing one phase interval; saturates at zero and
// can be frozen by hold. Load wins over hold.
module phase_timer #(
    parameter int              CNT_W     = 8,
    parameter logic [CNT_W-1:0] RESET_VAL = {CNT_W{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // Countdown register: reset, reload on phase entry, otherwise step toward zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= RESET_VAL;
        end else if (load) begin
            count_r <= load_val;
        end else if (hold || (count_r == {CNT_W{1'b0}})) begin
            count_r <= count_r;
        end else begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/multi_phase_light_ctrl.sv
// Moore controller cycling ALLRED -> GREEN -> YELLOW across NUM_APPROACH approaches,
// with demand-driven skipping, green rest and emergency all-red preemption.
module multi_phase_light_ctrl
    import light_ctrl_pkg::*;
#(
    parameter int NUM_APPROACH  = 4,
    parameter int GREEN_CYCLES  = 8,
    parameter int YELLOW_CYCLES = 3,
    parameter int ALLRED_CYCLES = 2,
    parameter int SKIP_EMPTY    = 1,
    parameter int CNT_W         = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_APPROACH-1:0]           demand,
    input  logic                              preempt,
    output logic [3*NUM_APPROACH-1:0]         lights,
    output logic [$clog2(NUM_APPROACH)-1:0]   active_idx,
    output logic [1:0]                        phase,
    output logic                              phase_done
);

    localparam int               IDX_W  = $clog2(NUM_APPROACH);
    localparam logic [CNT_W-1:0] AR_LD  = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [CNT_W-1:0] GR_LD  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YE_LD  = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_APPROACH - 1);

    logic [1:0]              phase_r;
    logic [1:0]              phase_nxt_s;
    logic [IDX_W-1:0]        idx_r;
    logic [IDX_W-1:0]        idx_nxt_s;
    logic [IDX_W-1:0]        next_req_s;
    logic [IDX_W-1:0]        rr_next_s;
    logic [IDX_W-1:0]        sel_s;
    logic [NUM_APPROACH-1:0] self_mask_s;
    logic                    any_req_s;
    logic                    other_req_s;
    logic                    t_load_s;
    logic                    t_hold_s;
    logic [CNT_W-1:0]        t_val_s;
    logic                    t_zero_s;

    phase_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (AR_LD)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load_s),
        .load_val (t_val_s),
        .hold     (t_hold_s),
        .zero     (t_zero_s)
    );

    // Circular search after idx_r; scanning far-to-near lets the nearest requester win,
    // and the final candidate is idx_r itself so a sole requester is served again.
    always_comb begin
        next_req_s = idx_r;
        for (int k = NUM_APPROACH; k >= 1; k--) begin
            next_req_s = demand[(int'(idx_r) + k) % NUM_APPROACH]
                       ? IDX_W'((int'(idx_r) + k) % NUM_APPROACH) : next_req_s;
        end
    end

    assign rr_next_s   = (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
    assign sel_s       = (SKIP_EMPTY != 0) ? next_req_s : rr_next_s;
    assign self_mask_s = {{(NUM_APPROACH-1){1'b0}}, 1'b1} << idx_r;
    assign any_req_s   = |demand;
    assign other_req_s = |(demand & ~self_mask_s);

    // Phase sequencing; preempt is checked before any demand-driven decision.
    always_comb begin
        phase_nxt_s = phase_r;
        idx_nxt_s   = idx_r;
        t_load_s    = 1'b0;
        t_hold_s    = 1'b0;
        t_val_s     = AR_LD;
        case (phase_r)
            PH_ALLRED: begin
                if (preempt) begin
                    t_load_s = 1'b1;
                    t_val_s  = AR_LD;
                end else if (t_zero_s) begin
                    if ((SKIP_EMPTY != 0) && !any_req_s) begin
                        t_hold_s = 1'b1;
                    end else begin
                        phase_nxt_s = PH_GREEN;
                        idx_nxt_s   = sel_s;
                        t_load_s    = 1'b1;
                        t_val_s     = GR_LD;
                    end
                end else begin
                    t_hold_s = 1'b0;
                end
            end
            PH_GREEN: begin
                if (preempt) begin
                    phase_nxt_s = PH_YELLOW;
                    t_load_s    = 1'b1;
                    t_val_s     = YE_LD;
                end else if (t_zero_s) begin
                    if ((SKIP_EMPTY != 0) && !other_req_s) begin
                        t_hold_s = 1'b1;
                    end else begin
                        phase_nxt_s = PH_YELLOW;
                        t_load_s    = 1'b1;
                        t_val_s     = YE_LD;
                    end
                end else begin
                    t_hold_s = 1'b0;
                end
            end
            PH_YELLOW: begin
                if (t_zero_s) begin
                    phase_nxt_s = PH_ALLRED;
                    t_load_s    = 1'b1;
                    t_val_s     = AR_LD;
                end else begin
                    t_hold_s = 1'b0;
                end
            end
            default: begin
                phase_nxt_s = PH_ALLRED;
                t_load_s    = 1'b1;
                t_val_s     = AR_LD;
            end
        endcase
    end

    // State registers; reset parks on all-red with the last approach as "previous".
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r <= PH_ALLRED;
            idx_r   <= LAST_IDX;
        end else begin
            phase_r <= phase_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Lamp decode from registered state only.
    always_comb begin
        lights = {(3*NUM_APPROACH){1'b0}};
        for (int i = 0; i < NUM_APPROACH; i++) begin
            lights[3*i +: 3] = lamp_for(phase_r, idx_r == IDX_W'(i));
        end
    end

    assign phase      = phase_r;
    assign active_idx = idx_r;
    assign phase_done = t_zero_s;

endmodule

// File: tb/tb_multi_phase_light_ctrl.sv
// Scoreboard bench: an age-based reference model predicts each cycle's outputs for a
// demand-skipping instance and a fixed round-robin instance.
module tb_multi_phase_light_ctrl;

    localparam int N  = 4;
    localparam int G  = 8;
    localparam int Y  = 3;
    localparam int AR = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  demand;
    logic        preempt;
    logic [11:0] lights_a, lights_b;
    logic [1:0]  idx_a, idx_b, ph_a, ph_b;
    logic        done_a, done_b;

    always #5 clk = ~clk;

    multi_phase_light_ctrl #(.NUM_APPROACH(N), .GREEN_CYCLES(G), .YELLOW_CYCLES(Y),
        .ALLRED_CYCLES(AR), .SKIP_EMPTY(1), .CNT_W(8)) dut_skip (
        .clk(clk), .reset(reset), .demand(demand), .preempt(preempt),
        .lights(lights_a), .active_idx(idx_a), .phase(ph_a), .phase_done(done_a));

    multi_phase_light_ctrl #(.NUM_APPROACH(N), .GREEN_CYCLES(G), .YELLOW_CYCLES(Y),
        .ALLRED_CYCLES(AR), .SKIP_EMPTY(0), .CNT_W(8)) dut_rr (
        .clk(clk), .reset(reset), .demand(demand), .preempt(preempt),
        .lights(lights_b), .active_idx(idx_b), .phase(ph_b), .phase_done(done_b));

    typedef struct packed {
        logic [1:0] ph;
        logic [1:0] idx;
        logic [7:0] age;
    } mstate_t;

    typedef struct packed {
        logic [1:0]  ph;
        logic [1:0]  idx;
        logic [11:0] lights;
        logic        done;
    } exp_t;

    exp_t    q_a[$];
    exp_t    q_b[$];
    mstate_t ma, mb;
    int      n_checks = 0;
    int      n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp_v);
        end
    endtask

    function automatic int dur_of(input logic [1:0] ph);
        if (ph == 2'b00) return AR;
        else if (ph == 2'b01) return G;
        else return Y;
    endfunction

    function automatic mstate_t step(input mstate_t s, input logic [3:0] d, input logic p,
                                     input logic r, input bit skip);
        mstate_t    n = s;
        logic [3:0] others;
        int         pick = -1;
        if (r) begin
            n.ph = 2'b00; n.idx = 2'd3; n.age = 8'd0;
            return n;
        end
        case (s.ph)
            2'b00: begin
                if (p) n.age = 8'd0;
                else if (int'(s.age) < AR - 1) n.age = s.age + 8'd1;
                else if (skip && d == 4'b0000) n.age = s.age;
                else begin
                    if (!skip) pick = (int'(s.idx) + 1) % N;
                    else
                        for (int k = 1; k <= N; k++)
                            if (pick < 0 && d[(int'(s.idx) + k) % N]) pick = (int'(s.idx) + k) % N;
                    n.ph = 2'b01; n.idx = 2'(pick); n.age = 8'd0;
                end
            end
            2'b01: begin
                others = d & ~(4'b0001 << s.idx);
                if (p) begin n.ph = 2'b10; n.age = 8'd0; end
                else if (int'(s.age) < G - 1) n.age = s.age + 8'd1;
                else if (skip && others == 4'b0000) n.age = s.age;
                else begin n.ph = 2'b10; n.age = 8'd0; end
            end
            default: begin
                if (int'(s.age) < Y - 1) n.age = s.age + 8'd1;
                else begin n.ph = 2'b00; n.age = 8'd0; end
            end
        endcase
        return n;
    endfunction

    function automatic exp_t expect_of(input mstate_t s);
        exp_t e;
        e.ph   = s.ph;
        e.idx  = s.idx;
        e.done = (int'(s.age) == dur_of(s.ph) - 1);
        for (int i = 0; i < N; i++) begin
            if (int'(s.idx) == i && s.ph == 2'b01)      e.lights[3*i +: 3] = 3'b001;
            else if (int'(s.idx) == i && s.ph == 2'b10) e.lights[3*i +: 3] = 3'b010;
            else                                         e.lights[3*i +: 3] = 3'b100;
        end
        return e;
    endfunction

    task automatic cycle(input logic [3:0] d, input logic p, input logic r);
        exp_t ea, eb;
        @(negedge clk);
        demand = d; preempt = p; reset = r;
        ma = step(ma, d, p, r, 1'b1);
        mb = step(mb, d, p, r, 1'b0);
        q_a.push_back(expect_of(ma));
        q_b.push_back(expect_of(mb));
        @(posedge clk);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        check_eq("skip.phase",  32'(ph_a),     32'(ea.ph));
        check_eq("skip.idx",    32'(idx_a),    32'(ea.idx));
        check_eq("skip.lights", 32'(lights_a), 32'(ea.lights));
        check_eq("skip.done",   32'(done_a),   32'(ea.done));
        check_eq("rr.phase",    32'(ph_b),     32'(eb.ph));
        check_eq("rr.idx",      32'(idx_b),    32'(eb.idx));
        check_eq("rr.lights",   32'(lights_b), 32'(eb.lights));
        check_eq("rr.done",     32'(done_b),   32'(eb.done));
    endtask

    task automatic run(input logic [3:0] d, input logic p, input int n);
        for (int i = 0; i < n; i++) cycle(d, p, 1'b0);
    endtask

    task automatic run_until(input logic [3:0] d, input logic [1:0] ph, input logic [1:0] idx,
                             input int age, input int budget);
        int hit = 0;
        for (int i = 0; i < budget && hit == 0; i++) begin
            if (ma.ph == ph && ma.idx == idx && int'(ma.age) == age) hit = 1;
            else cycle(d, 1'b0, 1'b0);
        end
        check_eq("wait_state", 32'(hit), 32'd1);
    endtask

    initial begin
        ma = '0; mb = '0;
        demand = 4'b0000; preempt = 1'b0; reset = 1'b1;

        // Reset with full demand: fixed reset image, then approach 0 after two all-red cycles.
        cycle(4'b1111, 1'b0, 1'b1);
        check_eq("rst.lights", 32'(lights_a), 32'h924);
        check_eq("rst.idx",    32'(idx_a),    32'd3);
        check_eq("rst.done",   32'(done_a),   32'd0);
        run(4'b1111, 1'b0, 2);
        check_eq("first.phase", 32'(ph_a),  32'd1);
        check_eq("first.idx",   32'(idx_a), 32'd0);
        run(4'b1111, 1'b0, 70);

        // Single requester rests in green, then yields as soon as another approach asks.
        cycle(4'b0100, 1'b0, 1'b1);
        run(4'b0100, 1'b0, 30);
        check_eq("rest.phase", 32'(ph_a),  32'd1);
        check_eq("rest.idx",   32'(idx_a), 32'd2);
        cycle(4'b0101, 1'b0, 1'b0);
        check_eq("yield.phase", 32'(ph_a), 32'd2);
        run(4'b0101, 1'b0, 20);

        // Preempt raised in the third green cycle of approach 1, held ten cycles.
        cycle(4'b1111, 1'b0, 1'b1);
        run_until(4'b1111, 2'b01, 2'd1, 2, 60);
        run(4'b1111, 1'b1, 10);
        check_eq("pre.phase", 32'(ph_a), 32'd0);
        run(4'b1111, 1'b0, 30);

        // Reset pulsed mid-yellow of approach 3.
        cycle(4'b1111, 1'b0, 1'b1);
        run_until(4'b1111, 2'b10, 2'd3, 0, 80);
        cycle(4'b1111, 1'b0, 1'b1);
        check_eq("midrst.phase", 32'(ph_a),  32'd0);
        check_eq("midrst.idx",   32'(idx_a), 32'd3);
        run(4'b1111, 1'b0, 20);

        // No demand: skip instance parks in all-red, round-robin keeps cycling.
        cycle(4'b0000, 1'b0, 1'b1);
        run(4'b0000, 1'b0, 60);
        check_eq("idle.done", 32'(done_a), 32'd1);

        // Random demand with occasional preempt.
        cycle(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 75; i++) begin
            logic [3:0] d;
            d = 4'($urandom_range(0, 15));
            for (int j = 0; j < 4; j++) cycle(d, ($urandom_range(0, 19) == 0), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_phase_light_ctrl.md
MULTI_PHASE_LIGHT_CTRL -- requirements
Module: multi_phase_light_ctrl

Interface
REQ-001 Parameter NUM_APPROACH, default 4: number of controlled approaches; legal range 2..8.
REQ-002 Parameter GREEN_CYCLES, default 8: minimum green duration in clock cycles; legal range 1..2^CNT_W-1.
REQ-003 Parameter YELLOW_CYCLES, default 3: yellow duration in cycles; legal range 1..2^CNT_W-1.
REQ-004 Parameter ALLRED_CYCLES, default 2: all-red clearance duration in cycles; legal range 1..2^CNT_W-1.
REQ-005 Parameter SKIP_EMPTY, default 1: 1 = serve only approaches with demand; 0 = fixed round-robin.
REQ-006 Parameter CNT_W, default 8: phase timer width.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 demand  in  NUM_APPROACH  per-approach vehicle-present flag, level-sensitive, sampled every cycle.
REQ-010 preempt  in  1  emergency request; forces and holds all-red while high.
REQ-011 lights  out  3*NUM_APPROACH  lights[3*i+:3] = {R,Y,G} of approach i; one-hot.
REQ-012 active_idx  out  $clog2(NUM_APPROACH)  approach currently or most recently given green.
REQ-013 phase  out  2  current phase: ALLRED, GREEN or YELLOW.
REQ-014 phase_done  out  1  one-cycle pulse in the last cycle of every phase interval.

Function
REQ-015 Three-state FSM: ALLRED, GREEN, YELLOW; all outputs are decoded from registered state only (Moore, no input-to-output path).
REQ-016 In ALLRED every approach shows red (100).
REQ-017 In GREEN approach active_idx shows green (001); all others red.
REQ-018 In YELLOW approach active_idx shows yellow (010); all others red.
REQ-019 On phase entry the down-counter loads duration-1; a phase lasts exactly its duration; phase_done asserts when counter = 0.
REQ-020 ALLRED expiry: select next approach = first index after active_idx, wrapping NUM_APPROACH-1 -> 0, with demand set (SKIP_EMPTY=1) or simply active_idx+1 mod NUM_APPROACH (SKIP_EMPTY=0); go GREEN.
REQ-021 ALLRED expiry with SKIP_EMPTY=1 and demand all zero: remain ALLRED, counter holds at 0, re-evaluate every cycle; phase_done stays high while held.
REQ-022 The search of REQ-020 includes active_idx itself as the final candidate (sole requester is re-served).
REQ-023 GREEN expiry: go YELLOW, except with SKIP_EMPTY=1 and no demand on any other approach: green rest, stay GREEN with counter held at 0 until another approach has demand, then YELLOW next cycle.
REQ-024 YELLOW expiry: go ALLRED.
REQ-025 preempt high in GREEN: next cycle YELLOW with full YELLOW_CYCLES, regardless of counter.
REQ-026 preempt high in YELLOW: yellow completes normally.
REQ-027 preempt high in ALLRED: counter reloads ALLRED_CYCLES-1 every cycle; after preempt falls a full ALLRED_CYCLES elapse before REQ-020 selection.
REQ-028 preempt and demand change in the same cycle: preempt takes priority.

Reset
REQ-029 reset high: next edge sets phase=ALLRED, counter=ALLRED_CYCLES-1, active_idx=NUM_APPROACH-1, phase_done=0, all lights red; applies from any state, including mid-phase.
REQ-030 After reset release the first green goes to the first demanding approach from index 0 (SKIP_EMPTY=1) or approach 0 (SKIP_EMPTY=0).

Structure
REQ-031 Shared package light_ctrl_pkg holds light constants RED=100, YELLOW=010, GREEN=001 and phase enum ALLRED=00, GREEN=01, YELLOW=10.
REQ-032 Counter is a sub-module phase_timer (CNT_W-bit loadable down-counter with hold and zero flag).

Verification (NUM_APPROACH=4, GREEN=8, YELLOW=3, ALLRED=2)
REQ-033 Reset, demand=1111, SKIP_EMPTY=1 -> ALLRED 2 cycles, approach 0 green 8, yellow 3, ALLRED 2, approach 1 green; sequence 0,1,2,3,0.
REQ-034 demand=0100 only -> approach 2 green, holds in rest beyond 8 cycles; raise demand[0] -> next cycle YELLOW on 2, then ALLRED 2, approach 0 green.
REQ-035 Preempt asserted in cycle 3 of green on approach 1 -> next cycle yellow 3 cycles, ALLRED held for 10-cycle preempt, then 2 more ALLRED cycles, approach 2 green.
REQ-036 Reset pulsed during yellow of approach 3 -> following cycle all lights red, phase=ALLRED, active_idx=3; then approach 0 green after 2 cycles.
REQ-037 demand=0000: SKIP_EMPTY=1 -> ALLRED indefinitely with phase_done high; SKIP_EMPTY=0 -> full 0,1,2,3 cycle, 13-cycle period per approach.
